// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the runtime-programmable serial pattern detector:
//   FSM state encodings and default parameter values.
//   Optional feature macro used by the other files: SEQ_DET_CNT_EN.
package seq_det_pkg;

  localparam logic [1:0] S_UNCFG = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  typedef enum logic [1:0] {
    UNCFG = S_UNCFG,
    ARMED = S_ARMED,
    ERR   = S_ERR
  } state_t;

  localparam int DEF_PAT_W = 6;
  localparam int DEF_LEN_W = 3;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_det_if.sv
// seq_det_if
//   Bundles the configuration, serial data and status signals of the pattern
//   detector.
//   master : configuration / bit source (drives cfg_*, in_*; observes status)
//   slave  : the detector
//   Signals: cfg_load, cfg_pat[PAT_W], cfg_len[LEN_W], cfg_ovl, in_valid,
//            in_bit, match, cfg_err, armed, match_cnt[CNT_W] (SEQ_DET_CNT_EN).
//   Macro SEQ_DET_CNT_EN adds the CNT_W parameter and the match_cnt signal.
interface seq_det_if #(
  parameter int PAT_W = 6,
  parameter int LEN_W = 3
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
);

  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             in_valid;
  logic             in_bit;
  logic             match;
  logic             cfg_err;
  logic             armed;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  modport master (
    output cfg_load, cfg_pat, cfg_len, cfg_ovl, in_valid, in_bit,
    input  match, cfg_err, armed
`ifdef SEQ_DET_CNT_EN
    ,
    input  match_cnt
`endif
  );

  modport slave (
    input  cfg_load, cfg_pat, cfg_len, cfg_ovl, in_valid, in_bit,
    output match, cfg_err, armed
`ifdef SEQ_DET_CNT_EN
    ,
    output match_cnt
`endif
  );

endinterface

// File: rtl/seq_det_satcnt.sv
// seq_det_satcnt
//   CNT_W-wide saturating event counter with synchronous clear.
//   Ports: clk, rstn (async active-low), clr (clear, has priority),
//          inc (count one event), cnt (current count).
module seq_det_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count stops at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_det.sv
// seq_pattern_det
//   Runtime-programmable serial bit-pattern detector. A pattern of 1..PAT_W
//   bits and an overlap mode are loaded with cfg_load; each in_valid bit is
//   shifted into a history register and compared against the low cfg_len bits
//   of the pattern. A hit produces a one-cycle registered match pulse.
//   Ports: clk, rstn (async active-low), bus (seq_det_if.slave):
//     cfg_load/cfg_pat/cfg_len/cfg_ovl  configuration load
//     in_valid/in_bit                   serial input
//     match                             one-cycle hit pulse
//     cfg_err / armed                   configuration status levels
//     match_cnt                         saturating hit count (SEQ_DET_CNT_EN)
//   Macro SEQ_DET_CNT_EN enables the match counter and the CNT_W parameter.
module seq_pattern_det
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W
`ifdef SEQ_DET_CNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input logic       clk,
  input logic       rstn,
  seq_det_if.slave  bus
);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  // Only PAT_W-1 bits of history are stored: the newest bit comes straight
  // from in_bit when the comparison is made.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic             match_q;

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W:0]   fill_p1;
  logic [LEN_W-1:0] fill_sat;
  logic             len_bad;
  logic             accept;
  logic             hit;

  assign hist_nxt = {hist, bus.in_bit};
  // One extra bit so fill+1 cannot wrap when PAT_W is 2**LEN_W-1.
  assign fill_p1  = {1'b0, fill} + (LEN_W+1)'(1);
  assign fill_sat = (fill == LEN_W'(PAT_W)) ? fill : fill_p1[LEN_W-1:0];
  assign len_bad  = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(PAT_W));
  // A load in the same cycle as a valid bit discards the bit.
  assign accept   = (state == ARMED) && bus.in_valid && !bus.cfg_load;

  // Selects the low len_q bits of the post-shift history for comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hit = (fill_p1 >= {1'b0, len_q}) &&
               (((hist_nxt ^ pat_q) & len_mask) == '0);

  // Controller: config capture, history shift, fill tracking and match pulse.
  // In non-overlap mode a hit restarts fill so len fresh bits are needed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (bus.cfg_load) begin
        pat_q <= bus.cfg_pat;
        len_q <= bus.cfg_len;
        ovl_q <= bus.cfg_ovl;
        hist  <= '0;
        fill  <= '0;
        state <= len_bad ? ERR : ARMED;
      end else if (accept) begin
        hist    <= hist_nxt[PAT_W-2:0];
        match_q <= hit;
        if (hit && !ovl_q) begin
          fill <= '0;
        end else begin
          fill <= fill_sat;
        end
      end
    end
  end

  assign bus.match   = match_q;
  assign bus.armed   = (state == ARMED);
  assign bus.cfg_err = (state == ERR);

`ifdef SEQ_DET_CNT_EN
  seq_det_satcnt #(
    .CNT_W (CNT_W)
  ) u_satcnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.cfg_load),
    .inc  (accept && hit),
    .cnt  (bus.match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_pattern_det.sv
// tb_seq_pattern_det
//   Scoreboard bench for seq_pattern_det. Each driven cycle pushes the
//   hand-computed expected status into a queue; a monitor pops one entry
//   after every rising edge and compares. Match counter checks are active
//   when SEQ_DET_CNT_EN is defined (bench uses CNT_W=2).
module tb_seq_pattern_det;
  import seq_det_pkg::*;

`ifdef SEQ_DET_CNT_EN
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;
`else
  localparam int CNT_MAX = 255;
`endif

  typedef struct {
    logic  m;
    logic  a;
    logic  e;
    int    c;
    string tag;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  // Bench-side model of the status levels and match count.
  logic m_armed;
  logic m_err;
  int   m_cnt;

`ifdef SEQ_DET_CNT_EN
  seq_det_if #(.PAT_W(6), .LEN_W(3), .CNT_W(CNT_W)) bus ();
  seq_pattern_det #(.PAT_W(6), .LEN_W(3), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );
`else
  seq_det_if #(.PAT_W(6), .LEN_W(3)) bus ();
  seq_pattern_det #(.PAT_W(6), .LEN_W(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the expected
  // status to be seen after the following rising edge.
  task automatic applyStimulus(input string tag, input logic load, input logic [5:0] pat,
                               input logic [2:0] len, input logic ovl, input logic valid,
                               input logic bitv, input logic exp_m);
    exp_t e;
    @(negedge clk);
    bus.cfg_load = load;
    bus.cfg_pat  = pat;
    bus.cfg_len  = len;
    bus.cfg_ovl  = ovl;
    bus.in_valid = valid;
    bus.in_bit   = bitv;
    if (load) begin
      m_armed = !((len == 3'd0) || (len > 3'd6));
      m_err   = !m_armed;
      m_cnt   = 0;
    end else if (exp_m && (m_cnt < CNT_MAX)) begin
      m_cnt++;
    end
    e.m = exp_m; e.a = m_armed; e.e = m_err; e.c = m_cnt; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic loadCfg(input string tag, input logic [5:0] pat, input logic [2:0] len,
                         input logic ovl);
    applyStimulus(tag, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends n bits MSB-first; exp_m bit n-1 is the expectation for the first bit.
  task automatic sendStream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp_m);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus($sformatf("%s_b%0d", tag, n - i), 1'b0, bus.cfg_pat, bus.cfg_len,
                    bus.cfg_ovl, 1'b1, bits[i], exp_m[i]);
    end
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, bus.cfg_pat, bus.cfg_len, bus.cfg_ovl, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAsyncZero(input string tag);
    checkOutput({tag, "_match"}, int'(bus.match), 0);
    checkOutput({tag, "_armed"}, int'(bus.armed), 0);
    checkOutput({tag, "_err"}, int'(bus.cfg_err), 0);
`ifdef SEQ_DET_CNT_EN
    checkOutput({tag, "_cnt"}, int'(bus.match_cnt), 0);
`endif
  endtask

  // Monitor: compares one queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.tag, "_match"}, int'(bus.match), int'(e.m));
        checkOutput({e.tag, "_armed"}, int'(bus.armed), int'(e.a));
        checkOutput({e.tag, "_err"}, int'(bus.cfg_err), int'(e.e));
`ifdef SEQ_DET_CNT_EN
        checkOutput({e.tag, "_cnt"}, int'(bus.match_cnt), e.c);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wait_cycles;
    n_checks = 0; n_pass = 0;
    m_armed = 1'b0; m_err = 1'b0; m_cnt = 0;
    bus.cfg_load = 1'b0; bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_ovl = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    rstn = 1'b0;
    #1;
    checkAsyncZero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Unconfigured: bits are ignored.
    sendStream("uncfg", 16'b101, 3, 16'b000);

    // 010110, len 6, overlapping: second hit reuses bit 6.
    loadCfg("ld_p6_ovl", 6'b010110, 3'd6, 1'b1);
    sendStream("p6_ovl", 16'b01011010110, 11, 16'b00000100001);

    // Same stream non-overlapping: bits 7..11 are too few for a new match.
    loadCfg("ld_p6_novl", 6'b010110, 3'd6, 1'b0);
    sendStream("p6_novl", 16'b01011010110, 11, 16'b00000100000);
    sendStream("p6_novl2", 16'b010110, 6, 16'b000001);

    // 101, len 3.
    loadCfg("ld_p3_ovl", 6'b000101, 3'd3, 1'b1);
    sendStream("p3_ovl", 16'b10101, 5, 16'b00101);
    loadCfg("ld_p3_novl", 6'b000101, 3'd3, 1'b0);
    sendStream("p3_novl", 16'b10101, 5, 16'b00100);

    // Idle cycle in the middle of a pattern holds the history.
    loadCfg("ld_p3_gap", 6'b000101, 3'd3, 1'b1);
    sendStream("gap_a", 16'b10, 2, 16'b00);
    idleCycle("gap_idle");
    sendStream("gap_b", 16'b1, 1, 16'b1);

    // Bad lengths.
    loadCfg("ld_len0", 6'b010110, 3'd0, 1'b0);
    sendStream("len0", 16'b010110, 6, 16'b000000);
    loadCfg("ld_len7", 6'b010110, 3'd7, 1'b0);
    sendStream("len7", 16'b010110, 6, 16'b000000);
    loadCfg("ld_len6", 6'b010110, 3'd6, 1'b0);

    // Load colliding with a completing bit: bit dropped, history cleared.
    sendStream("mid_a", 16'b01011, 5, 16'b00000);
    applyStimulus("mid_ld", 1'b1, 6'b010110, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    sendStream("mid_b", 16'b010110, 6, 16'b000001);

    // Length 1.
    loadCfg("ld_len1_ovl", 6'b000001, 3'd1, 1'b1);
    sendStream("len1_ovl", 16'b101, 3, 16'b101);
    loadCfg("ld_len1", 6'b000001, 3'd1, 1'b0);
    sendStream("len1", 16'b111111, 6, 16'b111111);

    // Async reset while match is high.
    @(posedge clk);
    #3;
    checkOutput("pre_rst_match", int'(bus.match), 1);
    rstn = 1'b0;
    #1;
    checkAsyncZero("async_rst");
    m_armed = 1'b0; m_err = 1'b0; m_cnt = 0;
    bus.in_valid = 1'b0; bus.cfg_load = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    sendStream("post_rst", 16'b1, 1, 16'b0);

    wait_cycles = 0;
    while ((exp_q.size() > 0) && (wait_cycles < 10)) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    #2;
    checkOutput("drain_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
